// File: rtl/data_memory_lsu_if.sv
// Request/response channel between the MEM-stage requester and the data memory LSU.
// The master drives requests and the slave (the LSU) drives readiness and responses.
interface data_memory_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed data RAM with RV32I load/store sizing and a fixed-latency request/response FSM.
// Illegal, misaligned and out-of-range accesses are reported through rsp_err and never touch memory.
module data_memory_lsu #(
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 1,
    parameter int ADDR_W      = 32
) (
    input logic               clk,
    input logic               reset,
    data_memory_lsu_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, commit, mem_we;

    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        mem_q [DEPTH_BYTES];

    logic [IDX_W-1:0]  idx;
    logic [7:0]        lane [4];
    logic [2:0]        size_m1;
    logic [ADDR_W:0]   last_addr;
    logic              legal, misalign, oor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request is frozen at acceptance so the requester may change req_* freely afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        idx     = addr_q[IDX_W-1:0];
        case (f3_q[1:0])
            2'b00:   size_m1 = 3'd0;
            2'b01:   size_m1 = 3'd1;
            default: size_m1 = 3'd3;
        endcase
        legal     = wr_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                         : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign  = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        // One extra bit keeps the end-address compare from wrapping near the top of the address space.
        last_addr = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, size_m1};
        oor       = last_addr >= (ADDR_W+1)'(DEPTH_BYTES);
        err_d     = !legal || misalign || oor;
        mem_we    = commit && wr_q && !err_d;

        for (int i = 0; i < 4; i++) begin
            lane[i] = mem_q[idx + IDX_W'(i)];
        end

        rdata_d = '0;
        if (!err_d && !wr_q) begin
            case (f3_q)
                3'b000:  rdata_d = {{24{lane[0][7]}}, lane[0]};
                3'b001:  rdata_d = {{16{lane[1][7]}}, lane[1], lane[0]};
                3'b010:  rdata_d = {lane[3], lane[2], lane[1], lane[0]};
                3'b100:  rdata_d = {24'd0, lane[0]};
                3'b101:  rdata_d = {16'd0, lane[1], lane[0]};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[idx] <= wdata_q[7:0];
            if (f3_q[1:0] != 2'b00) begin
                mem_q[idx + IDX_W'(1)] <= wdata_q[15:8];
            end
            if (f3_q[1:0] == 2'b10) begin
                mem_q[idx + IDX_W'(2)] <= wdata_q[23:16];
                mem_q[idx + IDX_W'(3)] <= wdata_q[31:24];
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: a transaction-level memory model checked every cycle,
// plus literal expectations for the documented load/store scenarios.
module tb_data_memory_lsu;
    localparam int DEPTH = 128;
    localparam int LAT   = 3;
    localparam int AW    = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_memory_lsu_if #(.ADDR_W(AW)) bus ();

    data_memory_lsu #(
        .DEPTH_BYTES(DEPTH),
        .LATENCY    (LAT),
        .ADDR_W     (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-array reference memory; accesses follow the RV32I sizing and error rules directly.
    logic [7:0] mmem [DEPTH];

    function automatic void model_access(input logic w, input logic [2:0] f3,
                                         input logic [AW-1:0] a, input logic [31:0] wd,
                                         output logic e, output logic [31:0] rd);
        longint ua;
        int     size;
        bit     legal;
        logic [31:0] raw;
        ua  = longint'(a);
        rd  = 32'd0;
        e   = 1'b0;
        raw = 32'd0;
        if (w) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (!legal || (ua % size) != 0 || ua + size > DEPTH) begin
            e = 1'b1;
            return;
        end
        if (w) begin
            for (int i = 0; i < size; i++) mmem[int'(ua) + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) raw[8*i +: 8] = mmem[int'(ua) + i];
            case (f3)
                3'd0:    rd = {{24{raw[7]}}, raw[7:0]};
                3'd1:    rd = {{16{raw[15]}}, raw[15:0]};
                default: rd = raw;
            endcase
        end
    endfunction

    // Timing model: a request taken at edge N resolves at edge N+LAT; the next cycle is the response.
    bit          seen_rst = 1'b0;
    bit          pend     = 1'b0;
    bit          m_resp   = 1'b0;
    bit          was_ready;
    int          left;
    logic        p_w;
    logic [2:0]  p_f3;
    logic [AW-1:0] p_a;
    logic [31:0] p_wd;
    logic [31:0] m_rdata;
    logic        m_err;

    always @(posedge clk) begin
        if (!reset) begin
            pend     = 1'b0;
            m_resp   = 1'b0;
            m_rdata  = 32'd0;
            m_err    = 1'b0;
            seen_rst = 1'b1;
        end else begin
            was_ready = !pend && !m_resp;
            m_resp    = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    model_access(p_w, p_f3, p_a, p_wd, m_err, m_rdata);
                    m_resp = 1'b1;
                    pend   = 1'b0;
                end
            end else if (was_ready && bus.req_valid) begin
                pend = 1'b1;
                left = LAT;
                p_w  = bus.req_write;
                p_f3 = bus.req_funct3;
                p_a  = bus.req_addr;
                p_wd = bus.req_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!pend && !m_resp));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            end
        end
    end

    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit wait_rsp);
        bit acc;
        bit rdy;
        acc = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
        end
        #1;
        bus.req_valid  = 1'b0;
        bus.req_write  = ~w;
        bus.req_funct3 = f3 ^ 3'b111;
        bus.req_addr   = a + 32'd4;
        bus.req_wdata  = ~wd;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (!wait_rsp) return;
        r_lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                r_lat = k;
                break;
            end
        end
        if (r_lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
        r_rdata = bus.rsp_rdata;
        r_err   = bus.rsp_err;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp,
                      input string name);
        issue(1'b0, f3, a, 32'd0, 1'b1);
        chk({name, "_rdata"}, r_rdata, exp);
        chk({name, "_err"}, 32'(r_err), 32'd0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input string name);
        issue(1'b1, f3, a, wd, 1'b1);
        chk({name, "_rdata"}, r_rdata, 32'd0);
        chk({name, "_err"}, 32'(r_err), 32'd0);
    endtask

    task automatic bad(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input string name);
        issue(w, f3, a, 32'hFFFF_FFFF, 1'b1);
        chk({name, "_rdata"}, r_rdata, 32'd0);
        chk({name, "_err"}, 32'(r_err), 32'd1);
    endtask

    int pulses;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = 32'd0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);

        st(3'b010, 32'd20, 32'hDEAD_BEEF, "sw20");
        chk("sw_latency", 32'(r_lat), 32'(LAT + 1));
        ld(3'b010, 32'd20, 32'hDEAD_BEEF, "lw20");

        ld(3'b000, 32'd23, 32'hFFFF_FFDE, "lb23");
        ld(3'b100, 32'd23, 32'h0000_00DE, "lbu23");
        ld(3'b001, 32'd22, 32'hFFFF_DEAD, "lh22");
        ld(3'b101, 32'd22, 32'h0000_DEAD, "lhu22");
        ld(3'b000, 32'd20, 32'hFFFF_FFEF, "lb20");

        st(3'b000, 32'd21, 32'h1234_5655, "sb21");
        ld(3'b010, 32'd20, 32'hDEAD_55EF, "lw20_sb");

        bad(1'b0, 3'b010, 32'd22, "lw22_misal");
        bad(1'b1, 3'b001, 32'd21, "sh21_misal");
        bad(1'b0, 3'b010, 32'(DEPTH - 2), "lw_top");
        bad(1'b0, 3'b011, 32'd20, "ld_f3_011");
        bad(1'b1, 3'b100, 32'd20, "st_f3_100");
        bad(1'b0, 3'b000, 32'(DEPTH), "lb_oor");
        bad(1'b1, 3'b010, 32'h8000_0014, "sw_high");
        ld(3'b010, 32'd20, 32'hDEAD_55EF, "lw20_after_err");

        st(3'b010, 32'(DEPTH - 4), 32'hA5A5_5A5A, "sw_last");
        ld(3'b101, 32'(DEPTH - 2), 32'h0000_A5A5, "lhu_last");
        ld(3'b001, 32'(DEPTH - 2), 32'hFFFF_A5A5, "lh_last");
        ld(3'b000, 32'(DEPTH - 1), 32'hFFFF_FFA5, "lb_last");
        bad(1'b0, 3'b001, 32'(DEPTH - 1), "lh_last_misal");

        st(3'b010, 32'd40, 32'h1122_3344, "sw40");
        issue(1'b1, 3'b010, 32'd40, 32'hCAFE_F00D, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) pulses++;
            if (k == 0) chk("ready_after_midrst", 32'(bus.req_ready), 32'd1);
        end
        chk("no_rsp_after_midrst", 32'(pulses), 32'd0);
        ld(3'b010, 32'd40, 32'h1122_3344, "lw40_after_midrst");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
